ahb_subordinate_synth: RTL and testbench
========================================

Name: ahb_subordinate_synth

Overview:
- Synthesizable AHB-Lite subordinate: word-addressed SRAM with byte and halfword write strobes, a configurable number of wait states, and a two-cycle ERROR response for illegal accesses.
- It is the counterpart of the existing synthesizable AHB manager. Renode's AHB manager model drives it over renode_ahb_if, so firmware running in Renode can read and write HDL-side memory.

Parameters:
- AddressWidth, 32, HADDR width.
- DataWidth, 32, HWDATA/HRDATA width; only 32 is supported.
- MemoryWords, 1024, number of 32-bit words; byte addresses at or above 4*MemoryWords are out of range.
- WaitStates, 0, HREADYOUT-low cycles inserted in each OKAY data phase; legal range 0..15.

Ports:
- HCLK  input  1  bus clock, rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HSEL  input  1  subordinate select.
- HADDR  input  AddressWidth  byte address, address phase.
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
- HWDATA  input  DataWidth  write data, data phase.
- HREADY  input  1  bus-level ready; the system ties it to HREADYOUT.
- HREADYOUT  output  1  data phase completes this cycle.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- HRDATA  output  DataWidth  read data.

Behaviour:
- Reset (HRESET high, asynchronous): FSM goes to IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, captured address-phase registers cleared. Memory contents are not reset.
- Address-phase acceptance: an access is accepted on a rising edge where HSEL & HREADY & HTRANS[1]. On that edge the block captures HADDR[AddressWidth-1:2], HADDR[1:0], HSIZE and HWRITE.
- An access is illegal if any of these holds:
  - HSIZE>2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]!=0;
  - HADDR>=4*MemoryWords.
- IDLE/BUSY transfers, or HSEL=0 with HREADY=1: no data phase follows. Outputs stay HREADYOUT=1, HRESP=0.
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: legal access, wait counter running.
  - DATA: final cycle of an OKAY data phase.
  - ERR1, ERR2: the two cycles of the ERROR response.
- Transitions:
  - Legal access accepted → WAIT if WaitStates>0 (counter loaded with WaitStates-1), else DATA.
  - Illegal access accepted → ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements; at 0 → DATA.
  - DATA: HREADYOUT=1, HRESP=0. On the edge ending DATA: back to IDLE, or directly to WAIT/DATA/ERR1 if a new access is accepted on that same edge (pipelined back-to-back).
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 → IDLE, or a new access per the acceptance rule.
- Write:
  - Memory updates on the edge ending DATA, using HWDATA sampled in that cycle.
  - Byte lane enables come from the captured size and address: byte → lane HADDR[1:0]; halfword → lanes {HADDR[1],0} and {HADDR[1],1}; word → all lanes. Little-endian.
  - Unselected lanes are unchanged.
  - Errored writes never modify memory.
- Read:
  - In DATA, HRDATA = mem[captured word index], the full word with all lanes; the manager selects lanes.
  - Outside DATA of a read, HRDATA=0.
  - A read whose data phase directly follows a write data phase to the same word returns the newly written data, because the commit happens on the edge that starts the read data phase.
- Accepting a new address phase while HREADYOUT=0 is impossible, since HREADY=HREADYOUT.
- HSEL deasserting during a data phase does not abort it.
- Reset mid-transfer abandons the transfer: no memory write, outputs go to their reset values immediately.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x10, WaitStates=0 → read data phase HRDATA=0xDEADBEEF; both data phases last 1 cycle with HREADYOUT=1, HRESP=0.
- After the above, byte write 0xAA in lane 1 @0x11, then halfword write 0x1234 @0x12, then word read @0x10 → 0x1234AAEF.
- WaitStates=3, word read → HREADYOUT low exactly 3 cycles, data on the 4th; back-to-back NONSEQ reads at 0x0 and 0x4 → each data phase is 4 cycles.
- Write @4*MemoryWords, misaligned word @0x2, and HSIZE=3 → each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1). A later read of the targeted in-range words shows them unchanged.
- HTRANS=IDLE and BUSY, and HSEL=0 with NONSEQ → HREADYOUT stays 1, HRESP stays 0, no memory change.
- Assert HRESET during WAIT of a write (WaitStates=2) → HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously; the target word is unchanged on a later read.

Source files
------------

// File: rtl/ahb_subordinate_synth.sv
// AHB-Lite subordinate: word-addressed SRAM with byte/halfword strobes,
// configurable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_subordinate_synth #(
   parameter int unsigned AddressWidth = 32,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned MemoryWords  = 1024,
   parameter int unsigned WaitStates   = 0
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic                    HSEL,
   input  logic [AddressWidth-1:0] HADDR,
   input  logic [1:0]              HTRANS,
   input  logic                    HWRITE,
   input  logic [2:0]              HSIZE,
   input  logic [DataWidth-1:0]    HWDATA,
   input  logic                    HREADY,
   output logic                    HREADYOUT,
   output logic                    HRESP,
   output logic [DataWidth-1:0]    HRDATA
);

   localparam int unsigned IdxW = $clog2(MemoryWords);
   localparam logic [AddressWidth-1:0] MemBytes = AddressWidth'(4 * MemoryWords);
   localparam logic [3:0] WaitLoad = 4'((WaitStates > 0) ? (WaitStates - 1) : 0);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   logic [DataWidth-1:0] r_mem [MemoryWords];

   state_t               r_state;
   logic [3:0]           r_cnt;
   logic [IdxW-1:0]      r_idx;
   logic [1:0]           r_lo;
   logic [2:0]           r_size;
   logic                 r_write;
   logic                 r_ready;
   logic                 r_resp;
   logic [DataWidth-1:0] r_rdata;

   logic                 w_accept;
   logic                 w_illegal;
   logic [IdxW-1:0]      w_idx;
   logic [3:0]           w_lanes;
   logic [DataWidth-1:0] w_wr_word;
   logic [DataWidth-1:0] w_rd_word;

   assign w_accept  = HSEL & HREADY & ((HTRANS == 2'b10) | (HTRANS == 2'b11));
   assign w_illegal = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                    | (HADDR >= MemBytes);
   assign w_idx     = HADDR[IdxW+1:2];

   always_comb begin
      case (r_size)
         3'd0:    w_lanes = 4'b0001 << r_lo;
         3'd1:    w_lanes = r_lo[1] ? 4'b1100 : 4'b0011;
         default: w_lanes = 4'b1111;
      endcase
   end

   // Merge write data into the stored word; also the forwarding source for a following read.
   always_comb begin
      w_wr_word = r_mem[r_idx];
      for (int i = 0; i < 4; i++) begin
         if (w_lanes[i]) w_wr_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
   end

   assign w_rd_word = ((r_state == S_DATA) && r_write && (r_idx == w_idx)) ? w_wr_word : r_mem[w_idx];

   always_ff @(posedge HCLK) begin
      if ((r_state == S_DATA) && r_write) r_mem[r_idx] <= w_wr_word;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_lo    <= 2'd0;
         r_size  <= 3'd0;
         r_write <= 1'b0;
         r_ready <= 1'b1;
         r_resp  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_rdata <= '0;
         case (r_state)
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_DATA;
                  r_ready <= 1'b1;
                  if (!r_write) r_rdata <= r_mem[r_idx];
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_ERR1: begin
               r_state <= S_ERR2;
               r_ready <= 1'b1;
               r_resp  <= 1'b1;
            end
            default: begin
               // IDLE, DATA and ERR2 all end on an edge where a new address phase may be taken.
               if (w_accept) begin
                  r_idx   <= w_idx;
                  r_lo    <= HADDR[1:0];
                  r_size  <= HSIZE;
                  r_write <= HWRITE;
                  if (w_illegal) begin
                     r_state <= S_ERR1;
                     r_ready <= 1'b0;
                     r_resp  <= 1'b1;
                  end else if (WaitStates > 0) begin
                     r_state <= S_WAIT;
                     r_cnt   <= WaitLoad;
                     r_ready <= 1'b0;
                     r_resp  <= 1'b0;
                  end else begin
                     r_state <= S_DATA;
                     r_ready <= 1'b1;
                     r_resp  <= 1'b0;
                     if (!HWRITE) r_rdata <= w_rd_word;
                  end
               end else begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
                  r_resp  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign HREADYOUT = r_ready;
   assign HRESP     = r_resp;
   assign HRDATA    = r_rdata;

endmodule

// File: tb/tb_ahb_subordinate_synth.sv
// Scoreboard bench: three subordinates (0, 3 and 2 wait states) on a shared bus,
// each data phase checked against expectations queued when its address phase is driven.
module tb_ahb_subordinate_synth;

   typedef struct {
      int          k;
      logic        err;
      logic        wr;
      logic [31:0] data;
      int          waits;
   } exp_t;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic [2:0]  hsel = 3'b000;
   logic [31:0] HADDR = '0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic [2:0]  HSIZE = 3'd0;
   logic [31:0] HWDATA = '0;
   logic [2:0]  w_hreadyout;
   logic [2:0]  w_hresp;
   logic [31:0] w_hrdata [3];

   int          n_checks = 0;
   int          n_errors = 0;
   int          ws [3] = '{0, 3, 2};
   exp_t        sb_q [$];
   logic [31:0] mdl [int];
   logic        pend [3] = '{1'b0, 1'b0, 1'b0};
   int          low_cnt [3] = '{0, 0, 0};
   logic        resp_low [3] = '{1'b0, 1'b0, 1'b0};
   logic        rdata_low [3] = '{1'b0, 1'b0, 1'b0};

   always #5 HCLK = ~HCLK;

   ahb_subordinate_synth #(.WaitStates(0)) u_ws0 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(w_hreadyout[0]),
      .HREADYOUT(w_hreadyout[0]), .HRESP(w_hresp[0]), .HRDATA(w_hrdata[0]));
   ahb_subordinate_synth #(.WaitStates(3)) u_ws3 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(w_hreadyout[1]),
      .HREADYOUT(w_hreadyout[1]), .HRESP(w_hresp[1]), .HRDATA(w_hrdata[1]));
   ahb_subordinate_synth #(.WaitStates(2)) u_ws2 (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(w_hreadyout[2]),
      .HREADYOUT(w_hreadyout[2]), .HRESP(w_hresp[2]), .HRDATA(w_hrdata[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [1:0] lo, input logic [2:0] sz);
      logic [31:0] r;
      logic        sel;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (sz == 3'd0)      sel = (b == int'(lo));
         else if (sz == 3'd1) sel = ((b / 2) == int'(lo[1]));
         else                 sel = 1'b1;
         if (sel) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   // Data-phase monitor: completes on HREADYOUT high, then notes a newly accepted address phase.
   always @(negedge HCLK) begin
      for (int k = 0; k < 3; k++) begin
         if (HRESET) begin
            pend[k] = 1'b0;
         end else begin
            if (pend[k]) begin
               if (!w_hreadyout[k]) begin
                  low_cnt[k]++;
                  resp_low[k] = resp_low[k] | w_hresp[k];
                  rdata_low[k] = rdata_low[k] | (w_hrdata[k] != 32'h0);
               end else begin
                  pend[k] = 1'b0;
                  check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                  if (sb_q.size() > 0) begin
                     exp_t e;
                     e = sb_q.pop_front();
                     check("dut_id", 32'(k), 32'(e.k));
                     check("hresp", 32'(w_hresp[k]), 32'(e.err));
                     check("wait_cycles", 32'(low_cnt[k]), 32'(e.waits));
                     check("hresp_low", 32'(resp_low[k]), 32'(e.err));
                     check("hrdata_low", 32'(rdata_low[k]), 32'd0);
                     if (!e.wr && !e.err) check("hrdata", w_hrdata[k], e.data);
                     else                 check("hrdata_zero", w_hrdata[k], 32'h0);
                  end
               end
            end
            if (hsel[k] && w_hreadyout[k] && HTRANS[1]) begin
               pend[k]      = 1'b1;
               low_cnt[k]   = 0;
               resp_low[k]  = 1'b0;
               rdata_low[k] = 1'b0;
            end
         end
      end
   end

   task automatic wait_ready(input int k);
      int n;
      n = 0;
      @(negedge HCLK);
      while (!w_hreadyout[k] && n < 64) begin
         @(negedge HCLK);
         n++;
      end
      check("ready_timeout", 32'(n < 64), 32'd1);
   endtask

   task automatic ahb_xfer(input int k, input logic [31:0] addr, input logic wr,
                           input logic [2:0] sz, input logic [31:0] wd, input logic err);
      exp_t e;
      int   key;
      key     = k * 65536 + int'(addr[15:2]);
      e.k     = k;
      e.err   = err;
      e.wr    = wr;
      e.waits = err ? 1 : ws[k];
      e.data  = '0;
      if (!err) begin
         if (wr) mdl[key] = merge(mdl.exists(key) ? mdl[key] : 32'h0, wd, addr[1:0], sz);
         else    e.data = mdl[key];
      end
      sb_q.push_back(e);
      hsel      = 3'b000;
      hsel[k]   = 1'b1;
      HADDR     = addr;
      HTRANS    = 2'b10;
      HWRITE    = wr;
      HSIZE     = sz;
      wait_ready(k);
      @(posedge HCLK); #1;
      hsel   = 3'b000;
      HTRANS = 2'b00;
      HWDATA = wd;
   endtask

   task automatic drain(input int k);
      wait_ready(k);
      @(posedge HCLK); #1;
   endtask

   task automatic no_data(input logic s, input logic [1:0] t);
      hsel   = {2'b00, s};
      HTRANS = t;
      HWRITE = 1'b1;
      HADDR  = 32'h10;
      HSIZE  = 3'd2;
      HWDATA = 32'hFFFF_FFFF;
      for (int c = 0; c < 2; c++) begin
         @(negedge HCLK);
         check("nd_ready", 32'(w_hreadyout[0]), 32'd1);
         check("nd_resp", 32'(w_hresp[0]), 32'd0);
         @(posedge HCLK); #1;
         hsel   = 3'b000;
         HTRANS = 2'b00;
      end
   endtask

   logic [31:0] err_addr [3] = '{32'h0000_1000, 32'h0000_0002, 32'h0000_0008};
   logic [2:0]  err_size [3] = '{3'd2, 3'd2, 3'd3};

   initial begin
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      for (int k = 0; k < 3; k++) begin
         check("rst_ready", 32'(w_hreadyout[k]), 32'd1);
         check("rst_resp", 32'(w_hresp[k]), 32'd0);
         check("rst_rdata", w_hrdata[k], 32'h0);
      end
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      @(posedge HCLK); #1;

      // Word write then pipelined read of the same word.
      ahb_xfer(0, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 1'b0);
      ahb_xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0);
      drain(0);

      // Byte and halfword strobes.
      ahb_xfer(0, 32'h11, 1'b1, 3'd0, 32'h0000_AA00, 1'b0);
      ahb_xfer(0, 32'h12, 1'b1, 3'd1, 32'h1234_0000, 1'b0);
      ahb_xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0);
      drain(0);

      // Three wait states, back-to-back reads.
      ahb_xfer(1, 32'h0, 1'b1, 3'd2, 32'h1111_1111, 1'b0);
      ahb_xfer(1, 32'h4, 1'b1, 3'd2, 32'h2222_2222, 1'b0);
      ahb_xfer(1, 32'h0, 1'b0, 3'd2, 32'h0, 1'b0);
      ahb_xfer(1, 32'h4, 1'b0, 3'd2, 32'h0, 1'b0);
      drain(1);

      // Illegal accesses answer ERROR and leave memory alone.
      ahb_xfer(0, 32'h0, 1'b1, 3'd2, 32'hCAFE_F00D, 1'b0);
      ahb_xfer(0, 32'h8, 1'b1, 3'd2, 32'h0BAD_C0DE, 1'b0);
      for (int i = 0; i < 3; i++) ahb_xfer(0, err_addr[i], 1'b1, err_size[i], 32'h5A5A_5A5A, 1'b1);
      ahb_xfer(0, 32'h1, 1'b1, 3'd1, 32'h5A5A_5A5A, 1'b1);
      ahb_xfer(0, 32'h0, 1'b0, 3'd2, 32'h0, 1'b0);
      ahb_xfer(0, 32'h8, 1'b0, 3'd2, 32'h0, 1'b0);
      drain(0);

      // IDLE, BUSY and unselected NONSEQ produce no data phase.
      no_data(1'b1, 2'b00);
      no_data(1'b1, 2'b01);
      no_data(1'b0, 2'b10);
      ahb_xfer(0, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0);
      drain(0);

      // Reset during the wait states of a write abandons it.
      ahb_xfer(2, 32'h20, 1'b1, 3'd2, 32'h5566_7788, 1'b0);
      drain(2);
      hsel   = 3'b100;
      HADDR  = 32'h20;
      HTRANS = 2'b10;
      HWRITE = 1'b1;
      HSIZE  = 3'd2;
      @(posedge HCLK); #1;
      hsel   = 3'b000;
      HTRANS = 2'b00;
      HWDATA = 32'hBAD0_BAD0;
      @(negedge HCLK);
      check("wait_ready_low", 32'(w_hreadyout[2]), 32'd0);
      #2;
      HRESET = 1'b1;
      #1;
      check("arst_ready", 32'(w_hreadyout[2]), 32'd1);
      check("arst_resp", 32'(w_hresp[2]), 32'd0);
      check("arst_rdata", w_hrdata[2], 32'h0);
      @(negedge HCLK);
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      @(posedge HCLK); #1;
      ahb_xfer(2, 32'h20, 1'b0, 3'd2, 32'h0, 1'b0);
      drain(2);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
